sprite_move_ctrl: RTL and testbench

//  Frame-stepped position controller for a player sprite (Pacman) in the VGA path. Parametrised

---
 rtl/sprite_move_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_move_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_ctrl.sv
// sprite_move_ctrl: frame-stepped sprite mover with buffered turns,
// collision rollback and edge wrap or clamp.
module sprite_move_ctrl #(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int SPEED           = 150,
  parameter int FP_SHIFT        = 6,
  parameter int OBJ_W           = 32,
  parameter int OBJ_H           = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SAFETY          = 2,
  parameter int WRAP_EN         = 1,
  parameter int TURN_BUF_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               playGame,
  input  logic               Y_up_key,
  input  logic               Y_down_key,
  input  logic               X_right_key,
  input  logic               X_left_key,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         face_direction,
  output logic               moving
);
  typedef enum logic [1:0] {
    IDLE, MOVE, WAIT_EOF, POS_CHANGE
  } state_t;

  localparam logic [1:0] DOWN  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] UP    = 2'b11;
  localparam int ONE = 1 << FP_SHIFT;
  localparam logic signed [31:0] INIT_X = INITIAL_X * ONE;
  localparam logic signed [31:0] INIT_Y = INITIAL_Y * ONE;
  localparam logic [3:0] TURN_CNT = 4'(TURN_BUF_FRAMES);

  state_t state, state_n;
  logic signed [31:0] pos_x, pos_y, prev_x, prev_y;
  logic signed [31:0] pos_x_n, pos_y_n, prev_x_n, prev_y_n;
  logic signed [31:0] step_x, step_y;
  logic [1:0] dir, dir_n, old_dir, old_dir_n;
  logic [1:0] req_dir, req_dir_n, key_dir, step_dir;
  logic [3:0] req_cnt, req_cnt_n;
  logic moving_n, req_valid, req_valid_n;
  logic trial, trial_n, col_seen, col_seen_n;
  logic go, go_n, key_any, step_en;

  function automatic logic signed [31:0] edge_fix(
    input logic signed [31:0] p,
    input int obj,
    input int scr
  );
    logic signed [31:0] px;
    logic signed [31:0] r;
    px = p >>> FP_SHIFT;
    r  = p;
    if (WRAP_EN != 0) begin
      if (px < -obj) r = (scr - 1) * ONE;
      else if (px > scr - 1) r = -obj * ONE;
    end else begin
      if (p < SAFETY * ONE) r = SAFETY * ONE;
      else if (p > (scr - SAFETY - obj) * ONE)
        r = (scr - SAFETY - obj) * ONE;
    end
    return r;
  endfunction

  always_comb begin
    key_any = Y_up_key | Y_down_key
            | X_right_key | X_left_key;
    if (Y_up_key) key_dir = UP;
    else if (Y_down_key) key_dir = DOWN;
    else if (X_right_key) key_dir = RIGHT;
    else key_dir = LEFT;
  end

  always_comb begin
    state_n     = state;
    pos_x_n     = pos_x;
    pos_y_n     = pos_y;
    prev_x_n    = prev_x;
    prev_y_n    = prev_y;
    dir_n       = dir;
    old_dir_n   = old_dir;
    moving_n    = moving;
    req_dir_n   = req_dir;
    req_valid_n = req_valid;
    req_cnt_n   = req_cnt;
    trial_n     = trial;
    col_seen_n  = col_seen;
    go_n        = go;
    step_x      = pos_x;
    step_y      = pos_y;
    step_dir    = dir;
    step_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (playGame) state_n = MOVE;
      end
      MOVE, WAIT_EOF: begin
        if (startOfFrame) state_n = POS_CHANGE;
        // a trial turn that hits a wall reverts but keeps retrying
        if (state == MOVE && playGame
            && collision && !col_seen) begin
          pos_x_n    = prev_x;
          pos_y_n    = prev_y;
          col_seen_n = 1'b1;
          if (trial) begin
            dir_n       = old_dir;
            trial_n     = 1'b0;
            req_valid_n = (req_cnt != 4'd0);
          end else begin
            moving_n = 1'b0;
            state_n  = WAIT_EOF;
          end
        end
        if (playGame && key_any) begin
          if (key_dir != dir) begin
            req_dir_n   = key_dir;
            req_valid_n = 1'b1;
            req_cnt_n   = TURN_CNT;
          end else if (!moving) begin
            go_n = 1'b1;
          end
        end
      end
      POS_CHANGE: begin
        state_n    = MOVE;
        col_seen_n = 1'b0;
        trial_n    = 1'b0;
        prev_x_n   = pos_x;
        prev_y_n   = pos_y;
        if (playGame) begin
          step_en = moving | go;
          go_n    = 1'b0;
          if (req_valid) begin
            old_dir_n   = dir;
            dir_n       = req_dir;
            step_dir    = req_dir;
            trial_n     = 1'b1;
            req_cnt_n   = req_cnt - 4'd1;
            req_valid_n = 1'b0;
            step_en     = 1'b1;
          end
          moving_n = step_en;
          if (step_en) begin
            unique case (step_dir)
              DOWN:  step_y = pos_y + SPEED;
              RIGHT: step_x = pos_x + SPEED;
              LEFT:  step_x = pos_x - SPEED;
              UP:    step_y = pos_y - SPEED;
            endcase
            pos_x_n = edge_fix(step_x, OBJ_W, SCREEN_W);
            pos_y_n = edge_fix(step_y, OBJ_H, SCREEN_H);
            if (WRAP_EN == 0 && (pos_x_n != step_x
                || pos_y_n != step_y))
              moving_n = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pos_x     <= INIT_X;
      pos_y     <= INIT_Y;
      prev_x    <= INIT_X;
      prev_y    <= INIT_Y;
      dir       <= RIGHT;
      old_dir   <= RIGHT;
      moving    <= 1'b0;
      req_dir   <= RIGHT;
      req_valid <= 1'b0;
      req_cnt   <= 4'd0;
      trial     <= 1'b0;
      col_seen  <= 1'b0;
      go        <= 1'b0;
    end else begin
      state     <= state_n;
      pos_x     <= pos_x_n;
      pos_y     <= pos_y_n;
      prev_x    <= prev_x_n;
      prev_y    <= prev_y_n;
      dir       <= dir_n;
      old_dir   <= old_dir_n;
      moving    <= moving_n;
      req_dir   <= req_dir_n;
      req_valid <= req_valid_n;
      req_cnt   <= req_cnt_n;
      trial     <= trial_n;
      col_seen  <= col_seen_n;
      go        <= go_n;
    end
  end

  assign topLeftX       = 11'(pos_x >>> FP_SHIFT);
  assign topLeftY       = 11'(pos_y >>> FP_SHIFT);
  assign face_direction = dir;
endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb_sprite_move_ctrl: wrap and clamp instances driven frame by frame
// against a per-frame behavioural model of the sprite rules.
module tb_sprite_move_ctrl;
  localparam int ONE = 64;
  localparam int SPD = 150;
  localparam bit [3:0] K_UP = 4'b1000;
  localparam bit [3:0] K_RT = 4'b0010;
  localparam bit [3:0] K_LT = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sof = 1'b0, play = 1'b0, col = 1'b0;
  logic k_up = 1'b0, k_dn = 1'b0;
  logic k_rt = 1'b0, k_lt = 1'b0;
  logic signed [10:0] tx_w, ty_w, tx_c, ty_c;
  logic [1:0] fd_w, fd_c;
  logic mv_w, mv_c;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_move_ctrl #(.WRAP_EN(1)) dut_w (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .playGame(play), .Y_up_key(k_up), .Y_down_key(k_dn),
    .X_right_key(k_rt), .X_left_key(k_lt),
    .collision(col), .topLeftX(tx_w), .topLeftY(ty_w),
    .face_direction(fd_w), .moving(mv_w));

  sprite_move_ctrl #(.WRAP_EN(0)) dut_c (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .playGame(play), .Y_up_key(k_up), .Y_down_key(k_dn),
    .X_right_key(k_rt), .X_left_key(k_lt),
    .collision(col), .topLeftX(tx_c), .topLeftY(ty_c),
    .face_direction(fd_c), .moving(mv_c));

  typedef struct {
    int x, y, px, py, dir, odir, rdir, rcnt;
    bit idle, mov, rv, trial, cs, go;
  } mdl_t;
  mdl_t m [2];

  function automatic int fl(int p);
    return (p - (((p % ONE) + ONE) % ONE)) / ONE;
  endfunction

  function automatic int m_edge(int p, int obj, int scr, bit wrap);
    int pix;
    pix = fl(p);
    if (wrap) begin
      if (pix < -obj) return (scr - 1) * ONE;
      if (pix > scr - 1) return -obj * ONE;
      return p;
    end
    if (p < 2 * ONE) return 2 * ONE;
    if (p > (scr - 2 - obj) * ONE) return (scr - 2 - obj) * ONE;
    return p;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].x = 280 * ONE; m[i].y = 185 * ONE;
      m[i].px = m[i].x; m[i].py = m[i].y;
      m[i].dir = 1; m[i].odir = 1; m[i].rdir = 1; m[i].rcnt = 0;
      m[i].idle = 1; m[i].mov = 0; m[i].rv = 0;
      m[i].trial = 0; m[i].cs = 0; m[i].go = 0;
    end
  endfunction

  function automatic void m_col(int i, bit p);
    if (!p || m[i].idle || m[i].cs) return;
    m[i].x = m[i].px; m[i].y = m[i].py; m[i].cs = 1;
    if (m[i].trial) begin
      m[i].dir = m[i].odir; m[i].trial = 0;
      m[i].rv = (m[i].rcnt != 0);
    end else m[i].mov = 0;
  endfunction

  // one frame: start pulse, step, keys, then two collision slots
  function automatic void m_frame(int i, bit [3:0] k,
                                  bit c1, bit c2, bit p);
    bit wrap, sm;
    int kd, nx, ny;
    wrap = (i == 0);
    if (m[i].idle) begin
      if (!p) return;
      m[i].idle = 0;
    end else begin
      m[i].cs = 0; m[i].trial = 0;
      m[i].px = m[i].x; m[i].py = m[i].y;
      if (p) begin
        sm = m[i].mov || m[i].go;
        m[i].go = 0;
        if (m[i].rv) begin
          m[i].odir = m[i].dir; m[i].dir = m[i].rdir;
          m[i].trial = 1; m[i].rcnt--; m[i].rv = 0; sm = 1;
        end
        m[i].mov = sm;
        if (sm) begin
          nx = m[i].x; ny = m[i].y;
          case (m[i].dir)
            0: ny += SPD;
            1: nx += SPD;
            2: nx -= SPD;
            default: ny -= SPD;
          endcase
          m[i].x = m_edge(nx, 32, 640, wrap);
          m[i].y = m_edge(ny, 32, 480, wrap);
          if (!wrap && (m[i].x != nx || m[i].y != ny)) m[i].mov = 0;
        end
      end
    end
    if (p && k != 0) begin
      kd = k[3] ? 3 : k[2] ? 0 : k[1] ? 1 : 2;
      if (kd != m[i].dir) begin
        m[i].rdir = kd; m[i].rv = 1; m[i].rcnt = 8;
      end else if (!m[i].mov) m[i].go = 1;
    end
    if (c1) m_col(i, p);
    if (c2) m_col(i, p);
  endfunction

  function automatic logic [24:0] obs_v(int i);
    if (i == 0) return {tx_w, ty_w, fd_w, mv_w};
    return {tx_c, ty_c, fd_c, mv_c};
  endfunction

  function automatic logic [24:0] exp_v(int i);
    logic [10:0] ex, ey;
    ex = 11'(fl(m[i].x));
    ey = 11'(fl(m[i].y));
    return {ex, ey, 2'(m[i].dir), m[i].mov};
  endfunction

  task automatic run_frame(input bit [3:0] k, input bit c1,
                           input bit c2, input bit p);
    @(negedge clk); sof = 1'b1; play = p;
    @(negedge clk); sof = 1'b0;
    @(negedge clk); {k_up, k_dn, k_rt, k_lt} = k;
    @(negedge clk); {k_up, k_dn, k_rt, k_lt} = 4'b0;
    @(negedge clk); col = c1;
    @(negedge clk); col = 1'b0;
    @(negedge clk); col = c2;
    @(negedge clk); col = 1'b0;
    for (int i = 0; i < 2; i++) m_frame(i, k, c1, c2, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sof = 1'b0; play = 1'b0; col = 1'b0;
    {k_up, k_dn, k_rt, k_lt} = 4'b0;
    @(negedge clk); reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_v(i) !== exp_v(i)) begin
        errors++;
        $display("FAIL reset[%0d] got %h want %h",
                 i, obs_v(i), exp_v(i));
      end
    end
    checks++;
    if (tx_w !== 11'sd280 || ty_w !== 11'sd185) begin
      errors++;
      $display("FAIL reset_pos got %0d,%0d want 280,185",
               tx_w, ty_w);
    end
  endtask

  task automatic test_straight();
    for (int f = 0; f < 66; f++) begin
      run_frame(f == 1 ? K_RT : 4'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL straight[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
    end
    checks++;
    if (tx_w !== 11'sd430 || ty_w !== 11'sd185
        || fd_w !== 2'b01 || mv_w !== 1'b1) begin
      errors++;
      $display("FAIL straight_64 got x=%0d y=%0d d=%0d m=%0d want 430 185 1 1",
               tx_w, ty_w, fd_w, mv_w);
    end
  endtask

  task automatic test_collision();
    for (int f = 0; f < 4; f++) begin
      run_frame(4'b0, f == 0, f == 0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL collision[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
      checks++;
      if (tx_w !== 11'sd430 || mv_w !== 1'b0) begin
        errors++;
        $display("FAIL collision_hold f%0d got x=%0d m=%0d want 430 0",
                 f, tx_w, mv_w);
      end
    end
  endtask

  task automatic test_turn_retry();
    bit [3:0] k;
    for (int f = 0; f < 14; f++) begin
      k = (f == 0) ? K_RT : (f == 2 || f == 12) ? K_UP : 4'b0;
      run_frame(k, f >= 3 && f <= 10, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL turn[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
      if (f >= 3 && f <= 11) begin
        checks++;
        if (fd_w !== 2'b01 || mv_w !== 1'b1) begin
          errors++;
          $display("FAIL turn_revert f%0d got d=%0d m=%0d want 1 1",
                   f, fd_w, mv_w);
        end
      end
    end
    checks++;
    if (fd_w !== 2'b11) begin
      errors++;
      $display("FAIL turn_accept got d=%0d want 3", fd_w);
    end
  endtask

  task automatic test_wrap();
    bit hit;
    hit = 1'b0;
    run_frame(K_LT, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 600 && !hit; f++) begin
      run_frame(4'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL wrap[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
      hit = (fl(m[0].x) == 639);
    end
    checks++;
    if (!hit || tx_w !== 11'sd639) begin
      errors++;
      $display("FAIL wrap_edge got x=%0d hit=%0d want 639 1",
               tx_w, hit);
    end
    checks++;
    if (tx_c !== 11'sd2 || mv_c !== 1'b0) begin
      errors++;
      $display("FAIL clamp_edge got x=%0d m=%0d want 2 0",
               tx_c, mv_c);
    end
  endtask

  task automatic test_freeze();
    int sx, sy;
    sx = fl(m[0].x);
    sy = fl(m[0].y);
    for (int f = 0; f < 8; f++) begin
      run_frame(f < 5 ? K_UP : 4'b0, f == 2, 1'b0, f >= 5);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL freeze[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
      if (f < 5) begin
        checks++;
        if (int'(tx_w) != sx || int'(ty_w) != sy) begin
          errors++;
          $display("FAIL freeze_hold f%0d got %0d,%0d want %0d,%0d",
                   f, tx_w, ty_w, sx, sy);
        end
      end
    end
    checks++;
    if (fd_w !== 2'b10 || mv_w !== 1'b1) begin
      errors++;
      $display("FAIL freeze_resume got d=%0d m=%0d want 2 1",
               fd_w, mv_w);
    end
  endtask

  task automatic test_reset_mid_trial();
    run_frame(K_UP, 1'b0, 1'b0, 1'b1);
    @(negedge clk); sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    @(negedge clk);
    checks++;
    if (fd_w !== 2'b11) begin
      errors++;
      $display("FAIL trial_start got d=%0d want 3", fd_w);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; play = 1'b0;
    m_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_v(i) !== exp_v(i)) begin
        errors++;
        $display("FAIL mid_reset[%0d] got %h want %h",
                 i, obs_v(i), exp_v(i));
      end
    end
    for (int f = 0; f < 4; f++) begin
      run_frame(f == 1 ? K_RT : 4'b0, f == 2, 1'b0, f > 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL after_reset[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
    end
  endtask

  task automatic test_random();
    bit [3:0] k;
    bit c1, c2, p;
    do_reset();
    for (int f = 0; f < 300; f++) begin
      k  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      c1 = ($urandom_range(3) == 0);
      c2 = ($urandom_range(7) == 0);
      p  = ($urandom_range(7) != 0);
      run_frame(k, c1, c2, p);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_v(i) !== exp_v(i)) begin
          errors++;
          $display("FAIL random[%0d] f%0d got %h want %h",
                   i, f, obs_v(i), exp_v(i));
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    test_reset();
    test_straight();
    test_collision();
    test_turn_retry();
    test_wrap();
    test_freeze();
    test_reset_mid_trial();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
